// File: rtl/matmul_scheduler.sv
// Sequences (A row, B col) pairs in row-major order: request each pair from the loader,
// wait for its data, then launch the compute unit and wait for the result.
module matmul_scheduler #(
  parameter int MAX_SIZE_A = 32,
  parameter int MAX_SIZE_B = 32,
  parameter int TIMEOUT    = 64,
  parameter int MAX_RETRY  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          complete,
  input  logic [$clog2(MAX_SIZE_A):0]   rows_a,
  input  logic [$clog2(MAX_SIZE_B):0]   cols_b,
  output logic                          req_valid,
  output logic [$clog2(MAX_SIZE_A)-1:0] req_row,
  output logic [$clog2(MAX_SIZE_B)-1:0] req_col,
  input  logic                          data_valid,
  input  logic [$clog2(MAX_SIZE_A)-1:0] data_row,
  input  logic [$clog2(MAX_SIZE_B)-1:0] data_col,
  output logic                          calc_start,
  output logic [$clog2(MAX_SIZE_A)-1:0] calc_row,
  output logic [$clog2(MAX_SIZE_B)-1:0] calc_col,
  input  logic                          calc_done,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);
  // state | meaning
  // IDLE  | waiting for a complete edge (error may be held)
  // REQ   | one-cycle request of the current pair
  // WAIT  | waiting for the loader to echo the pair, timing out into a retry
  // CALC  | compute unit running on the current pair
  // DONE  | all pairs computed, done held
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_CALC = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int RW  = $clog2(MAX_SIZE_A);
  localparam int CW  = $clog2(MAX_SIZE_B);
  localparam int RDW = RW + 1;
  localparam int CDW = CW + 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int NW  = $clog2(MAX_RETRY + 1);

  localparam logic [RDW-1:0] ROWS_MAX = RDW'(MAX_SIZE_A);
  localparam logic [CDW-1:0] COLS_MAX = CDW'(MAX_SIZE_B);
  localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [NW-1:0]  R_MAX    = NW'(MAX_RETRY);

  logic [2:0]     state;
  logic           complete_q;
  logic [RDW-1:0] rows_lat;
  logic [CDW-1:0] cols_lat;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [TW-1:0]  timer;
  logic [NW-1:0]  retry;

  logic start_evt;
  logic dims_bad;
  logic match;
  logic row_last;
  logic col_last;

  assign start_evt = complete && !complete_q;
  assign dims_bad  = (rows_a == '0) || (cols_b == '0) ||
                     (rows_a > ROWS_MAX) || (cols_b > COLS_MAX);
  assign match     = data_valid && (data_row == row) && (data_col == col);
  assign row_last  = ({1'b0, row} == rows_lat - RDW'(1));
  assign col_last  = ({1'b0, col} == cols_lat - CDW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      complete_q <= 1'b0;
      rows_lat   <= '0;
      cols_lat   <= '0;
      row        <= '0;
      col        <= '0;
      timer      <= '0;
      retry      <= '0;
      calc_start <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      complete_q <= complete;
      calc_start <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_evt) begin
            rows_lat <= rows_a;
            cols_lat <= cols_b;
            row      <= '0;
            col      <= '0;
            timer    <= '0;
            retry    <= '0;
            done     <= 1'b0;
            error    <= dims_bad;
            state    <= dims_bad ? ST_IDLE : ST_REQ;
          end
        end
        ST_REQ: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // a match on the final wait cycle takes priority over the retry
          if (match) begin
            calc_start <= 1'b1;
            state      <= ST_CALC;
          end else if (timer == T_LAST) begin
            if (retry < R_MAX) begin
              retry <= retry + NW'(1);
              state <= ST_REQ;
            end else begin
              error <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_CALC: begin
          if (calc_done) begin
            retry <= '0;
            if (row_last && col_last) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_REQ;
              if (col_last) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_valid = (state == ST_REQ);
  assign req_row   = row;
  assign req_col   = col;
  assign calc_row  = row;
  assign calc_col  = col;
  assign busy      = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_CALC);

endmodule
